// File: rtl/framebuffer_pixel_sink.sv
// Pixel-bus sink: queues (x,y,RGB) writes, range-checks them, linearises them to a
// framebuffer address and issues one RAM write per cycle; also runs whole-screen clears.

// Small synchronous FIFO with registered occupancy and a combinational read port.
// Latency: an entry pushed at edge N is visible on rdat_o after edge N.
// Backpressure: the caller must not push when full_o=1 or pop when empty_o=1.
module fbps_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             wdat_i,
  output logic [W-1:0]             rdat_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdat_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdat_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
endmodule

// Framebuffer write-port driver fed from the drawer pixel bus.
// Latency: pixel offered in cycle N to an idle block is written in cycle N+2.
// Backpressure: ready=0 when the FIFO is full; pixels offered then are dropped.
module framebuffer_pixel_sink #(
  parameter int FIFO_DEPTH = 8,
  parameter int X_MAX      = 160,
  parameter int Y_MAX      = 120,
  parameter int ADDR_W     = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vga_draw_enable_bus,
  input  logic [7:0]        vga_x_out_bus,
  input  logic [7:0]        vga_y_out_bus,
  input  logic [23:0]       vga_RGB_out_bus,
  input  logic              clear_req,
  input  logic [23:0]       clear_colour,
  output logic              ready,
  output logic              busy,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [23:0]       fb_wdata,
  output logic              overflow,
  output logic [7:0]        oob_count
);
  localparam int CW = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(X_MAX*Y_MAX-1);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_CLEAR} state_t;

  state_t            state_q;
  logic              fb_we_q, overflow_q, clr_pend_q;
  logic [ADDR_W-1:0] fb_addr_q, clr_cnt_q;
  logic [23:0]       fb_wdata_q, clr_colour_q;
  logic [7:0]        oob_q;

  logic              in_oob, in_ok, push, pop, full, empty;
  logic [CW:0]       fifo_cnt;
  logic [39:0]       rd_dat;
  logic [ADDR_W-1:0] pix_addr;

  assign in_oob = vga_draw_enable_bus &&
                  (int'(vga_x_out_bus) >= X_MAX || int'(vga_y_out_bus) >= Y_MAX);
  assign in_ok  = vga_draw_enable_bus && !in_oob;
  assign push   = in_ok && !full;
  // A pending clear takes priority over the queue once the block is idle.
  assign pop    = !empty && (state_q != S_CLEAR) && !(state_q == S_IDLE && clr_pend_q);

  fbps_fifo #(.W(40), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdat_i  ({vga_y_out_bus, vga_x_out_bus, vga_RGB_out_bus}),
    .rdat_o  (rd_dat),
    .full_o  (full),
    .empty_o (empty),
    .count_o (fifo_cnt)
  );

  assign pix_addr = ADDR_W'(rd_dat[39:32]) * ADDR_W'(X_MAX) + ADDR_W'(rd_dat[31:24]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      fb_we_q      <= 1'b0;
      fb_addr_q    <= '0;
      fb_wdata_q   <= '0;
      overflow_q   <= 1'b0;
      oob_q        <= '0;
      clr_pend_q   <= 1'b0;
      clr_colour_q <= '0;
      clr_cnt_q    <= '0;
    end else begin
      fb_we_q <= 1'b0;
      if (in_oob && oob_q != 8'hFF) oob_q <= oob_q + 8'd1;
      if (in_ok && full)            overflow_q <= 1'b1;
      if (clear_req && !clr_pend_q && state_q != S_CLEAR) begin
        clr_pend_q   <= 1'b1;
        clr_colour_q <= clear_colour;
      end
      case (state_q)
        S_CLEAR: begin
          fb_we_q    <= 1'b1;
          fb_addr_q  <= clr_cnt_q;
          fb_wdata_q <= clr_colour_q;
          clr_cnt_q  <= clr_cnt_q + ADDR_W'(1);
          if (clr_cnt_q == LAST_ADDR) state_q <= S_IDLE;
        end
        default: begin
          if (state_q == S_IDLE && clr_pend_q) begin
            // Address 0 is written on entry so the clear is X_MAX*Y_MAX cycles long.
            clr_pend_q <= 1'b0;
            fb_we_q    <= 1'b1;
            fb_addr_q  <= '0;
            fb_wdata_q <= clr_colour_q;
            clr_cnt_q  <= ADDR_W'(1);
            state_q    <= S_CLEAR;
          end else if (pop) begin
            fb_we_q    <= 1'b1;
            fb_addr_q  <= pix_addr;
            fb_wdata_q <= rd_dat[23:0];
            state_q    <= (fifo_cnt == (CW+1)'(1) && !push) ? S_IDLE : S_DRAIN;
          end else begin
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign ready     = !full;
  assign busy      = (state_q != S_IDLE) || !empty || clr_pend_q;
  assign fb_we     = fb_we_q;
  assign fb_addr   = fb_addr_q;
  assign fb_wdata  = fb_wdata_q;
  assign overflow  = overflow_q;
  assign oob_count = oob_q;
endmodule

// File: tb/tb_framebuffer_pixel_sink.sv
// Directed bench for framebuffer_pixel_sink; writes are logged at negedge and checked
// against hand-computed addresses, colours and cycle counts.
module tb_framebuffer_pixel_sink;
  logic        clk = 1'b0;
  logic        rst, de, clr;
  logic [7:0]  px, py;
  logic [23:0] prgb, clr_col;
  logic        ready, busy, fb_we, overflow;
  logic [14:0] fb_addr;
  logic [23:0] fb_wdata;
  logic [7:0]  oob_count;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  logic [14:0] wa[$];
  logic [23:0] wd[$];
  int          wc[$];

  framebuffer_pixel_sink dut (
    .clk                 (clk),
    .reset               (rst),
    .vga_draw_enable_bus (de),
    .vga_x_out_bus       (px),
    .vga_y_out_bus       (py),
    .vga_RGB_out_bus     (prgb),
    .clear_req           (clr),
    .clear_colour        (clr_col),
    .ready               (ready),
    .busy                (busy),
    .fb_we               (fb_we),
    .fb_addr             (fb_addr),
    .fb_wdata            (fb_wdata),
    .overflow            (overflow),
    .oob_count           (oob_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fb_we) begin
      wa.push_back(fb_addr);
      wd.push_back(fb_wdata);
      wc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic log_clear();
    wa.delete();
    wd.delete();
    wc.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; de = 1'b0; clr = 1'b0;
    tick(); tick();
    rst = 1'b0;
    log_clear();
  endtask

  task automatic pix(input logic [7:0] x, input logic [7:0] y, input logic [23:0] c);
    de = 1'b1; px = x; py = y; prgb = c;
  endtask

  task automatic wait_size(input int n, input int budget, input string tag);
    int k = 0;
    while (wa.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk(tag, 32'(wa.size() >= n), 32'd1);
  endtask

  task automatic check_clear(input int base, input logic [23:0] col, input string tag);
    int errs = 0;
    if (wa.size() >= base + 19200) begin
      for (int k = 0; k < 19200; k++)
        if (wa[base+k] != 15'(k) || wd[base+k] != col) errs++;
      chk({tag, "_span"}, 32'(wc[base+19199] - wc[base]), 32'd19199);
    end else begin
      errs = 1 << 20;
    end
    chk({tag, "_seq"}, 32'(errs), 32'd0);
  endtask

  initial begin
    int base;
    rst = 1'b1; de = 1'b0; clr = 1'b0; px = '0; py = '0; prgb = '0; clr_col = '0;
    do_reset();

    // Reset state
    chk("rst_we", 32'(fb_we), 0);
    chk("rst_addr", 32'(fb_addr), 0);
    chk("rst_wdata", 32'(fb_wdata), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_oob", 32'(oob_count), 0);
    chk("rst_ready", 32'(ready), 1);
    chk("rst_busy", 32'(busy), 0);

    // 1: single pixel, two-cycle latency, address 2*160+3
    pix(8'd3, 8'd2, 24'hFF0000);
    tick(); de = 1'b0;
    chk("t1_we_n1", 32'(fb_we), 0);
    tick();
    chk("t1_we_n2", 32'(fb_we), 1);
    chk("t1_addr", 32'(fb_addr), 32'd323);
    chk("t1_data", 32'(fb_wdata), 32'hFF0000);
    tick();
    chk("t1_we_n3", 32'(fb_we), 0);
    chk("t1_hold", 32'(fb_addr), 32'd323);
    chk("t1_busy", 32'(busy), 0);
    chk("t1_count", 32'(wa.size()), 1);

    // 3: out-of-range pixels, saturation, and the far-corner in-range pixel
    do_reset();
    pix(8'd160, 8'd0, 24'h111111); tick();
    pix(8'd0, 8'd120, 24'h222222); tick();
    de = 1'b0; tick(); tick(); tick();
    chk("t3_oob2", 32'(oob_count), 2);
    chk("t3_nowr", 32'(wa.size()), 0);
    chk("t3_busy", 32'(busy), 0);
    for (int i = 0; i < 300; i++) begin
      pix(8'd200, 8'd5, 24'h333333); tick();
    end
    de = 1'b0; tick();
    chk("t3_sat", 32'(oob_count), 32'd255);
    chk("t3_nowr2", 32'(wa.size()), 0);
    pix(8'd159, 8'd119, 24'h0A0B0C); tick();
    de = 1'b0; tick(); tick(); tick();
    chk("t3_corner_n", 32'(wa.size()), 1);
    if (wa.size() > 0) begin
      chk("t3_corner_a", 32'(wa[0]), 32'd19199);
      chk("t3_corner_d", 32'(wd[0]), 32'h0A0B0C);
    end

    // 4: full clear from idle; a second request mid-clear is ignored
    do_reset();
    clr = 1'b1; clr_col = 24'h00FF00; tick();
    clr = 1'b0; clr_col = 24'h0;
    wait_size(100, 200, "t4_start");
    clr = 1'b1; clr_col = 24'h0000FF; tick();
    clr = 1'b0;
    wait_size(19200, 20000, "t4_done");
    for (int i = 0; i < 50; i++) tick();
    chk("t4_total", 32'(wa.size()), 32'd19200);
    check_clear(0, 24'h00FF00, "t4");
    chk("t4_busy", 32'(busy), 0);

    // 2: ten pixels during a clear: 8 accepted, 2 dropped, drawn after the clear
    do_reset();
    clr = 1'b1; clr_col = 24'h123456; tick();
    clr = 1'b0;
    wait_size(5, 50, "t2_start");
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t2_ready%0d", i), 32'(ready), 32'(i < 8));
      pix(8'(10 + i), 8'(20 + i), 24'(24'h100 + i)); tick();
    end
    de = 1'b0;
    chk("t2_ovf", 32'(overflow), 1);
    chk("t2_busy", 32'(busy), 1);
    wait_size(19208, 20000, "t2_done");
    for (int i = 0; i < 20; i++) tick();
    chk("t2_total", 32'(wa.size()), 32'd19208);
    check_clear(0, 24'h123456, "t2");
    if (wa.size() >= 19208) begin
      for (int k = 0; k < 8; k++) begin
        chk($sformatf("t2_pa%0d", k), 32'(wa[19200+k]), 32'((20 + k) * 160 + 10 + k));
        chk($sformatf("t2_pd%0d", k), 32'(wd[19200+k]), 32'(24'h100 + k));
      end
    end

    // 5: clear requested while pixels are queued; a pixel sent mid-clear lands afterwards
    do_reset();
    pix(8'd1, 8'd0, 24'hA00001); tick();
    pix(8'd2, 8'd0, 24'hA00002); tick();
    pix(8'd3, 8'd0, 24'hA00003); tick();
    pix(8'd4, 8'd0, 24'hA00004); clr = 1'b1; clr_col = 24'hABCDEF; tick();
    de = 1'b0; clr = 1'b0;
    wait_size(20, 100, "t5_start");
    pix(8'd7, 8'd9, 24'h5A5A5A); tick();
    de = 1'b0;
    wait_size(19205, 20000, "t5_done");
    for (int i = 0; i < 20; i++) tick();
    chk("t5_total", 32'(wa.size()), 32'd19205);
    if (wa.size() >= 19205) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("t5_pa%0d", k), 32'(wa[k]), 32'(k + 1));
        chk($sformatf("t5_pd%0d", k), 32'(wd[k]), 32'(24'hA00001 + k));
      end
      chk("t5_late_a", 32'(wa[19204]), 32'd1447);
      chk("t5_late_d", 32'(wd[19204]), 32'h5A5A5A);
    end
    check_clear(4, 24'hABCDEF, "t5");

    // 6: reset at clear address 500 with a full FIFO and overflow set
    do_reset();
    clr = 1'b1; clr_col = 24'hFFFFFF; tick();
    clr = 1'b0;
    wait_size(3, 20, "t6_start");
    for (int i = 0; i < 10; i++) begin
      pix(8'(i), 8'd1, 24'h000777); tick();
    end
    de = 1'b0;
    chk("t6_ovf_pre", 32'(overflow), 1);
    begin
      int k = 0;
      while (!(fb_we && fb_addr == 15'd500) && k < 1000) begin
        tick();
        k++;
      end
      chk("t6_at500", 32'(fb_addr), 32'd500);
    end
    rst = 1'b1; tick();
    chk("t6_we", 32'(fb_we), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_ovf", 32'(overflow), 0);
    chk("t6_ready", 32'(ready), 1);
    rst = 1'b0;
    base = wa.size();
    for (int i = 0; i < 50; i++) tick();
    chk("t6_nowr", 32'(wa.size() - base), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
